// File: rtl/instr_fetch_3byte.sv
// Fetches fixed 3-byte instructions from a byte-wide synchronous memory.
// Each instruction is assembled into a 24-bit word and handed to the decoder over valid/ready.
module instr_fetch_3byte #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [23:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic [ADDR_W-1:0] pc_next,
   output logic              instr_valid,
   input  logic              instr_ready
);

   typedef enum logic [2:0] {S_START, S_RD0, S_RD1, S_RD2, S_CAP, S_HOLD} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_START;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (redirect) begin
         state_nxt = S_RD0;
      end else begin
         case (state)
            S_START: state_nxt = S_RD0;
            S_RD0:   state_nxt = S_RD1;
            S_RD1:   state_nxt = S_RD2;
            S_RD2:   state_nxt = S_CAP;
            S_CAP:   state_nxt = S_HOLD;
            S_HOLD:  if (instr_ready) state_nxt = S_RD0;
            default: state_nxt = S_START;
         endcase
      end
   end

   always_comb begin
      mem_rd      = 1'b0;
      mem_addr    = pc;
      instr_valid = 1'b0;
      case (state)
         S_RD0:   mem_rd = 1'b1;
         S_RD1:   begin mem_rd = 1'b1; mem_addr = pc + ADDR_W'(1); end
         S_RD2:   begin mem_rd = 1'b1; mem_addr = pc + ADDR_W'(2); end
         S_HOLD:  instr_valid = 1'b1;
         default: ;
      endcase
   end

   assign pc_next = instr_pc + ADDR_W'(3);

   // Each byte lands one cycle after its read; a redirect drops any partial capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         instr    <= '0;
         instr_pc <= RESET_PC;
      end else if (redirect) begin
         pc <= redirect_pc;
      end else begin
         case (state)
            S_RD1:  instr[23:16] <= mem_rdata;
            S_RD2:  instr[15:8]  <= mem_rdata;
            S_CAP:  begin instr[7:0] <= mem_rdata; instr_pc <= pc; end
            S_HOLD: if (instr_ready) pc <= pc + ADDR_W'(3);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_3byte.sv
// Directed bench for instr_fetch_3byte against a 1-cycle-latency byte memory model.
module tb_instr_fetch_3byte;
   localparam int          ADDR_W   = 16;
   localparam logic [15:0] RESET_PC = 16'h0010;

   logic        clk = 1'b0, rst_n = 1'b0, redirect = 1'b0, instr_ready = 1'b1;
   logic [15:0] redirect_pc = '0;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic [7:0]  mem_rdata = '0;
   logic [23:0] instr;
   logic [15:0] instr_pc, pc_next;
   logic        instr_valid;
   logic [7:0]  mem [0:65535];
   int          n_cmp = 0, n_err = 0, xfers = 0;

   instr_fetch_3byte #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc), .instr(instr), .instr_pc(instr_pc),
      .pc_next(pc_next), .instr_valid(instr_valid), .instr_ready(instr_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= mem[mem_addr];
      if (rst_n && instr_valid && instr_ready) xfers <= xfers + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic rd(input string tag, input logic r, input logic [15:0] a);
      chk({tag, ".mem_rd"}, 32'(mem_rd), 32'(r));
      if (r) chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(a));
   endtask

   task automatic out(input string tag, input logic v, input logic [23:0] w,
                      input logic [15:0] p, input logic [15:0] pn);
      chk({tag, ".valid"},   32'(instr_valid), 32'(v));
      chk({tag, ".instr"},   32'(instr),       32'(w));
      chk({tag, ".instr_pc"}, 32'(instr_pc),   32'(p));
      chk({tag, ".pc_next"}, 32'(pc_next),     32'(pn));
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h5A;
      mem[16'h0010] = 8'hA1; mem[16'h0011] = 8'hB2; mem[16'h0012] = 8'hC3;
      mem[16'h0013] = 8'h11; mem[16'h0014] = 8'h22; mem[16'h0015] = 8'h33;
      mem[16'hFFFE] = 8'hD4; mem[16'hFFFF] = 8'hE5; mem[16'h0000] = 8'hF6;
      mem[16'h0100] = 8'h44; mem[16'h0101] = 8'h55; mem[16'h0102] = 8'h66;
      mem[16'h0200] = 8'h77; mem[16'h0201] = 8'h88; mem[16'h0202] = 8'h99;

      // reset state
      tick(); tick();
      rd("rst", 1'b0, 16'h0);
      chk("rst.mem_addr", 32'(mem_addr), 32'h0010);
      out("rst", 1'b0, 24'h0, 16'h0010, 16'h0013);

      // first fetch from RESET_PC
      rst_n = 1'b1;
      tick(); rd("f1.rd0", 1'b1, 16'h0010);
      tick(); rd("f1.rd1", 1'b1, 16'h0011);
      tick(); rd("f1.rd2", 1'b1, 16'h0012);
      tick(); rd("f1.cap", 1'b0, 16'h0); chk("f1.cap.valid", 32'(instr_valid), 32'h0);
      tick(); out("f1.hold", 1'b1, 24'hA1B2C3, 16'h0010, 16'h0013); rd("f1.hold", 1'b0, 16'h0);

      // back-pressure on the second instruction
      tick(); rd("f2.rd0", 1'b1, 16'h0013);
      instr_ready = 1'b0;
      tick(); tick(); tick(); tick();
      for (int i = 0; i < 10; i++) begin
         out("bp", 1'b1, 24'h112233, 16'h0013, 16'h0016);
         rd("bp", 1'b0, 16'h0);
         tick();
      end
      instr_ready = 1'b1;
      tick(); rd("bp.next", 1'b1, 16'h0016);

      // wrap-around via redirect to FFFE
      redirect = 1'b1; redirect_pc = 16'hFFFE;
      tick(); redirect = 1'b0;
      rd("wr.rd0", 1'b1, 16'hFFFE);
      tick(); rd("wr.rd1", 1'b1, 16'hFFFF);
      tick(); rd("wr.rd2", 1'b1, 16'h0000);
      tick();
      tick(); out("wr.hold", 1'b1, 24'hD4E5F6, 16'hFFFE, 16'h0001);
      tick(); rd("wr.next", 1'b1, 16'h0001);

      // redirect while in RD2
      tick(); rd("mid.rd1", 1'b1, 16'h0002);
      tick(); rd("mid.rd2", 1'b1, 16'h0003);
      redirect = 1'b1; redirect_pc = 16'h0100;
      tick(); redirect = 1'b0;
      rd("mid.redir", 1'b1, 16'h0100);
      chk("mid.redir.valid", 32'(instr_valid), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick(); chk("mid.novalid", 32'(instr_valid), 32'h0);
      end
      tick(); out("mid.hold", 1'b1, 24'h445566, 16'h0100, 16'h0103);
      chk("mid.xfers", 32'(xfers), 32'd3);

      // redirect together with a handshake
      redirect = 1'b1; redirect_pc = 16'h0200;
      tick(); redirect = 1'b0;
      rd("sim.rd0", 1'b1, 16'h0200);
      chk("sim.valid", 32'(instr_valid), 32'h0);
      chk("sim.xfers", 32'(xfers), 32'd4);
      tick(); tick(); tick();
      tick(); out("sim.hold", 1'b1, 24'h778899, 16'h0200, 16'h0203);

      // async reset pulsed during RD1
      tick(); rd("ar.pre.rd0", 1'b1, 16'h0203);
      tick(); rd("ar.pre.rd1", 1'b1, 16'h0204);
      #2 rst_n = 1'b0;
      #1;
      rd("ar", 1'b0, 16'h0);
      chk("ar.mem_addr", 32'(mem_addr), 32'h0010);
      out("ar", 1'b0, 24'h0, 16'h0010, 16'h0013);
      #1 rst_n = 1'b1;
      tick(); rd("ar.rd0", 1'b1, 16'h0010);
      tick(); tick(); tick();
      tick(); out("ar.hold", 1'b1, 24'hA1B2C3, 16'h0010, 16'h0013);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
